// File: rtl/line_clear_engine.sv
// Row-compaction engine: scans the board bottom-up, drops full rows, shifts the
// survivors down and blanks the vacated top rows through one read and one write port.
module line_clear_engine #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
    output logic [4:0] rd_i,
    output logic [4:0] rd_j,
    input  logic [2:0] cell_type,
    output logic       wr_en,
    output logic [4:0] wr_i,
    output logic [4:0] wr_j,
    output logic [2:0] wr_type
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        FILL  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t            state_reg, state_next;
    logic [4:0]        src_reg, src_next;
    logic signed [5:0] dst_reg, dst_next;
    logic [4:0]        col_reg, col_next;
    logic              full_reg, full_next;
    logic [4:0]        cnt_reg, cnt_next;
    logic [4:0]        lines_reg, lines_next;
    logic [3*COLS-1:0] rowbuf_flat;
    logic [2:0]        rowbuf_sel;
    logic              advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            col_reg   <= '0;
            full_reg  <= 1'b0;
            cnt_reg   <= '0;
            lines_reg <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            col_reg   <= col_next;
            full_reg  <= full_next;
            cnt_reg   <= cnt_next;
            lines_reg <= lines_next;
        end
    end

    // One buffer cell per column, captured while that column is being read.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_rowbuf
            logic [2:0] cell_reg;
            always_ff @(posedge clk) begin
                if (state_reg == READ && col_reg == 5'(gi)) begin
                    cell_reg <= cell_type;
                end
            end
            assign rowbuf_flat[3*gi +: 3] = cell_reg;
        end
    endgenerate

    always_comb begin
        rowbuf_sel = 3'b000;
        for (int c = 0; c < COLS; c++) begin
            if (col_reg == 5'(c)) begin
                rowbuf_sel = rowbuf_flat[3*c +: 3];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        col_next   = col_reg;
        full_next  = full_reg;
        cnt_next   = cnt_reg;
        lines_next = lines_reg;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    src_next   = LAST_ROW;
                    dst_next   = 6'(ROWS - 1);
                    col_next   = '0;
                    cnt_next   = '0;
                    state_next = READ;
                end
            end
            READ: begin
                // Column 0 restarts the AND so no separate clear is needed per row.
                full_next = ((col_reg == 5'd0) ? 1'b1 : full_reg) & (cell_type != 3'b000);
                if (col_reg == LAST_COL) begin
                    col_next   = '0;
                    state_next = CHECK;
                end else begin
                    col_next = col_reg + 5'd1;
                end
            end
            CHECK: begin
                if (full_reg) begin
                    cnt_next = cnt_reg + 5'd1;
                    advance  = 1'b1;
                end else if (dst_reg != $signed({1'b0, src_reg})) begin
                    col_next   = '0;
                    state_next = WRITE;
                end else begin
                    dst_next = dst_reg - 6'sd1;
                    advance  = 1'b1;
                end
            end
            WRITE: begin
                if (col_reg == LAST_COL) begin
                    dst_next = dst_reg - 6'sd1;
                    advance  = 1'b1;
                end else begin
                    col_next = col_reg + 5'd1;
                end
            end
            FILL: begin
                if (col_reg == LAST_COL) begin
                    dst_next = dst_reg - 6'sd1;
                    col_next = '0;
                    if (dst_reg == 6'sd0) begin
                        state_next = DONE;
                    end
                end else begin
                    col_next = col_reg + 5'd1;
                end
            end
            DONE: begin
                lines_next = cnt_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Shared end-of-row decision; dst_next already reflects this row's decrement.
        if (advance) begin
            col_next = '0;
            if (src_reg == 5'd0) begin
                state_next = dst_next[5] ? DONE : FILL;
            end else begin
                src_next   = src_reg - 5'd1;
                state_next = READ;
            end
        end
    end

    always_comb begin
        busy          = (state_reg != IDLE);
        done          = (state_reg == DONE);
        lines_cleared = lines_reg;
        rd_i          = '0;
        rd_j          = '0;
        wr_en         = 1'b0;
        wr_i          = '0;
        wr_j          = '0;
        wr_type       = 3'b000;
        case (state_reg)
            READ: begin
                rd_i = src_reg;
                rd_j = col_reg;
            end
            WRITE: begin
                wr_en   = 1'b1;
                wr_i    = dst_reg[4:0];
                wr_j    = col_reg;
                wr_type = rowbuf_sel;
            end
            FILL: begin
                wr_en = 1'b1;
                wr_i  = dst_reg[4:0];
                wr_j  = col_reg;
            end
            default: ;
        endcase
    end

endmodule
